upsample2d_nearest: RTL and testbench
=====================================

Name: upsample2d_nearest

Overview:
- Streaming nearest-neighbour 2D upsampler; the inverse-direction companion to the pooling layers, used on decoder/expansion paths.
- Accepts one pixel per handshake in raster order, from a frame of DATA_IN_0_WIDTH x DATA_IN_0_HEIGHT.
- Emits DATA_OUT_0_WIDTH x DATA_OUT_0_HEIGHT pixels in raster order: each input pixel repeated SCALE_W times horizontally, and each input row repeated SCALE_H times vertically.
- A one-row line buffer holds the current row for the vertical repeats; valid/ready on both sides.

Parameters:
- DATA_IN_0_PRECISION_0, 8: pixel bit width.
- DATA_IN_0_PRECISION_1, 3: fractional bits; informational only.
- DATA_IN_0_PARALLELISM_DIM_0, 1: lanes; must be 1.
- DATA_IN_0_WIDTH, 4: input columns, >=1.
- DATA_IN_0_HEIGHT, 4: input rows, >=1.
- SCALE_W, 2: horizontal repeat factor, >=1.
- SCALE_H, 2: vertical repeat factor, >=1.
- DATA_OUT_0_PRECISION_0, 8: must equal DATA_IN_0_PRECISION_0.
- DATA_OUT_0_PRECISION_1, 3: must equal DATA_IN_0_PRECISION_1.
- DATA_OUT_0_WIDTH / DATA_OUT_0_HEIGHT: derived localparams, DATA_IN_0_WIDTH*SCALE_W and DATA_IN_0_HEIGHT*SCALE_H.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- data_in_0  in  DATA_IN_0_PRECISION_0 x1 lane  input pixel.
- data_in_0_valid  in  1  input valid.
- data_in_0_ready  out  1  input ready.
- data_out_0  out  DATA_OUT_0_PRECISION_0 x1 lane  output pixel.
- data_out_0_valid  out  1  output valid.
- data_out_0_ready  in  1  downstream ready.

Behaviour:
- Clock and reset: one clock domain (clk). rst is asynchronous and active-high.
- Reset values:
  - data_out_0_valid=0, data_out_0=0, data_in_0_ready=0 while rst is asserted.
  - State=LOAD; all counters (col, rep_w, rep_h, row) = 0.
  - Line buffer contents are don't-care.
- Output register:
  - data_out_0 and data_out_0_valid come from a register.
  - slot_free = !data_out_0_valid || data_out_0_ready.
  - While valid && !ready, data_out_0 holds stable.
  - If nothing is issued on a slot_free cycle, valid drops to 0.
- Pixel values pass through unchanged; no arithmetic on data.
- LOAD state (first copy of an input row):
  - data_in_0_ready = slot_free && rep_w==0 (combinational).
  - On accept:
    - output reg <= pixel, line_buf[col] <= pixel.
    - rep_w <= SCALE_W-1.
    - If SCALE_W==1, advance col immediately.
  - While rep_w>0 and slot_free: re-issue the same pixel, rep_w--.
  - When the last copy of a column is issued: col++.
  - On the last copy of col==DATA_IN_0_WIDTH-1: col<=0, then
    - if SCALE_H>1: go to REPLAY with rep_h<=1;
    - else: end of row (see below).
- REPLAY state:
  - data_in_0_ready=0.
  - Each slot_free cycle, issue line_buf[col], with the same rep_w/col sequencing as LOAD.
  - After the last column: if rep_h==SCALE_H-1, end of row; else rep_h++ and replay again.
- End of row: row++ and state=LOAD. At row==DATA_IN_0_HEIGHT-1, row wraps to 0 (frame done) and the next frame starts with no bubble.
- Latency and throughput:
  - First output valid is asserted the cycle after the first input handshake.
  - Sustained rate is 1 output/cycle when downstream is always ready.
  - Input duty is 1/(SCALE_W*SCALE_H) on average.
- Input stall in LOAD: when data_in_0_valid=0 and the slot is free, no output is issued and valid drops. No counter advances.
- Reset mid-frame: all state clears asynchronously. The partial frame is discarded. The next accepted pixel is treated as pixel (0,0).
- Elaboration asserts: precision equality between in and out; PARALLELISM_DIM_0==1.

Decomposition:
- Shared package (pooling_layers pkg): state enum {LOAD, REPLAY}; a $clog2-based counter-width helper.
- Sub-module upsample_line_buffer:
  - DATA_IN_0_WIDTH-entry register array.
  - One synchronous write port.
  - One asynchronous read port.
  - No RAM inference required.
- FSM, counters and output register stay in the top module.

Test Plan:
- 2x2 input, SCALE 2x2, ready=1, input [1,2,3,4] -> 16 beats: 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4; first valid 1 cycle after first accept.
- Same frame, data_out_0_ready toggling 1010… -> identical sequence; data_out_0 stable on every stalled cycle; no drops or duplicates.
- data_in_0_valid gaps of 3 cycles between pixels -> same sequence; valid deasserts during gaps; ready never asserted in REPLAY.
- SCALE_W=1, SCALE_H=1, 4x4 frame 0..15 -> passthrough, identical order, 1 beat/cycle.
- Two back-to-back frames [1,2,3,4] then [5,6,7,8] -> second frame's first output is 5, issued the cycle after the last 4 with no bubble.
- rst asserted after 6 outputs of the first scenario -> valid=0 immediately; after release, input [9,9,9,9] -> 16 beats of 9.

Source files
------------

// File: rtl/pooling_layers_pkg.sv
// Shared definitions for the pooling/upsampling layer family:
// FSM state encoding and a counter-width helper.
package pooling_layers_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_LOAD   = 1'b0;
  localparam state_t ST_REPLAY = 1'b1;

  // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/upsample_line_buffer.sv
// One-row line buffer: register array with one synchronous write port
// and one asynchronous read port.
module upsample_line_buffer
  import pooling_layers_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [cnt_width(DEPTH)-1:0] wr_addr,
  input  logic [DW-1:0]               wr_data,
  input  logic [cnt_width(DEPTH)-1:0] rd_addr,
  output logic [DW-1:0]               rd_data_c
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/upsample2d_nearest.sv
// Streaming nearest-neighbour 2D upsampler: each pixel repeated SCALE_W times
// across, each row repeated SCALE_H times down, replayed from a line buffer.
module upsample2d_nearest
  import pooling_layers_pkg::*;
#(
  parameter int unsigned DATA_IN_0_PRECISION_0       = 8,
  parameter int unsigned DATA_IN_0_PRECISION_1       = 3,
  parameter int unsigned DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int unsigned DATA_IN_0_WIDTH             = 4,
  parameter int unsigned DATA_IN_0_HEIGHT            = 4,
  parameter int unsigned SCALE_W                     = 2,
  parameter int unsigned SCALE_H                     = 2,
  parameter int unsigned DATA_OUT_0_PRECISION_0      = 8,
  parameter int unsigned DATA_OUT_0_PRECISION_1      = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);

  localparam int unsigned DATA_OUT_0_WIDTH  = DATA_IN_0_WIDTH * SCALE_W;
  localparam int unsigned DATA_OUT_0_HEIGHT = DATA_IN_0_HEIGHT * SCALE_H;

  localparam int unsigned DW    = DATA_IN_0_PRECISION_0;
  localparam int unsigned COL_W = cnt_width(DATA_IN_0_WIDTH);
  localparam int unsigned ROW_W = cnt_width(DATA_IN_0_HEIGHT);
  localparam int unsigned RW_W  = cnt_width(SCALE_W);
  localparam int unsigned RH_W  = cnt_width(SCALE_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(DATA_IN_0_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DATA_IN_0_HEIGHT - 1);
  localparam logic [RW_W-1:0]  RW_INIT  = RW_W'(SCALE_W - 1);
  localparam logic [RH_W-1:0]  RH_LAST  = RH_W'(SCALE_H - 1);

  if ((DATA_OUT_0_PRECISION_0 != DATA_IN_0_PRECISION_0) ||
      (DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1)) begin : g_bad_precision
    $error("upsample2d_nearest: input and output precisions must match");
  end
  if (DATA_IN_0_PARALLELISM_DIM_0 != 1) begin : g_bad_parallelism
    $error("upsample2d_nearest: only a single lane is supported");
  end
  if ((DATA_OUT_0_WIDTH < 1) || (DATA_OUT_0_HEIGHT < 1)) begin : g_bad_dims
    $error("upsample2d_nearest: frame dimensions and scales must be >= 1");
  end

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [RW_W-1:0]  rep_w_q, rep_w_d;
  logic [RH_W-1:0]  rep_h_q, rep_h_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             slot_free_c, accept_c, issue_c, first_c, last_c;
  logic [DW-1:0]    lb_rd_c, pix_c;

  upsample_line_buffer #(
    .DEPTH (DATA_IN_0_WIDTH),
    .DW    (DW)
  ) u_line_buf (
    .clk       (clk),
    .wr_en     (accept_c),
    .wr_addr   (col_q),
    .wr_data   (data_in_0),
    .rd_addr   (col_q),
    .rd_data_c (lb_rd_c)
  );

  // Issue/sequencing: rep_w counts copies still owed for the current column.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    rep_w_d     = rep_w_q;
    rep_h_d     = rep_h_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    slot_free_c     = !out_valid_q || data_out_0_ready;
    data_in_0_ready = !rst && (state_q == ST_LOAD) && (rep_w_q == '0) && slot_free_c;
    accept_c        = data_in_0_ready && data_in_0_valid;
    first_c         = (rep_w_q == '0);
    last_c          = first_c ? (SCALE_W == 1) : (rep_w_q == RW_W'(1));
    pix_c           = accept_c ? data_in_0 : lb_rd_c;

    if (state_q == ST_LOAD) issue_c = accept_c || (slot_free_c && !first_c);
    else                    issue_c = slot_free_c;

    if (slot_free_c) out_valid_d = 1'b0;

    if (issue_c) begin
      out_valid_d = 1'b1;
      out_data_d  = pix_c;
      rep_w_d     = first_c ? RW_INIT : rep_w_q - RW_W'(1);
      if (last_c) begin
        if (col_q != COL_LAST) begin
          col_d = col_q + COL_W'(1);
        end else begin
          col_d = '0;
          if ((state_q == ST_LOAD) && (SCALE_H > 1)) begin
            state_d = ST_REPLAY;
            rep_h_d = RH_W'(1);
          end else if ((state_q == ST_REPLAY) && (rep_h_q != RH_LAST)) begin
            rep_h_d = rep_h_q + RH_W'(1);
          end else begin
            // End of an output row group; frames chain with no bubble.
            state_d = ST_LOAD;
            rep_h_d = '0;
            row_d   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      col_q       <= '0;
      row_q       <= '0;
      rep_w_q     <= '0;
      rep_h_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      rep_w_q     <= rep_w_d;
      rep_h_q     <= rep_h_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out_0       = out_data_q;
  assign data_out_0_valid = out_valid_q;

endmodule

// File: tb/tb_upsample2d_nearest.sv
// Directed bench for upsample2d_nearest: a 2x2/scale-2x2 instance and a
// 4x4/scale-1x1 passthrough instance sharing clock and reset.
module tb_upsample2d_nearest;

  logic       clk;
  logic       rst;
  logic       use_pass;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;

  logic       a_in_ready, a_out_valid, p_in_ready, p_out_valid;
  logic [7:0] a_out, p_out;
  logic       o_valid, i_ready;
  logic [7:0] o_data;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] in_vec  [32];
  logic [7:0] exp_vec [64];
  int         pat     [16] = '{0, 0, 1, 1, 0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 3, 3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign o_valid = use_pass ? p_out_valid : a_out_valid;
  assign o_data  = use_pass ? p_out : a_out;
  assign i_ready = use_pass ? p_in_ready : a_in_ready;

  upsample2d_nearest #(
    .DATA_IN_0_WIDTH (2),
    .DATA_IN_0_HEIGHT(2),
    .SCALE_W         (2),
    .SCALE_H         (2)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (in_data),
    .data_in_0_valid  (in_valid && !use_pass),
    .data_in_0_ready  (a_in_ready),
    .data_out_0       (a_out),
    .data_out_0_valid (a_out_valid),
    .data_out_0_ready (out_ready || use_pass)
  );

  upsample2d_nearest #(
    .DATA_IN_0_WIDTH (4),
    .DATA_IN_0_HEIGHT(4),
    .SCALE_W         (1),
    .SCALE_H         (1)
  ) u_pass (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (in_data),
    .data_in_0_valid  (in_valid && use_pass),
    .data_in_0_ready  (p_in_ready),
    .data_out_0       (p_out),
    .data_out_0_valid (p_out_valid),
    .data_out_0_ready (out_ready || !use_pass)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Hand-expanded 2x2 frame at scale 2x2 into input slot f and output slot f.
  task automatic load_frame(input int f, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3);
    logic [7:0] px [4];
    px[0] = p0; px[1] = p1; px[2] = p2; px[3] = p3;
    for (int k = 0; k < 4; k++) in_vec[4*f + k] = px[k];
    for (int k = 0; k < 16; k++) exp_vec[16*f + k] = px[pat[k]];
  endtask

  // Drive n_in pixels with optional gaps and downstream toggling, checking every beat.
  task automatic run_stream(input string name, input int n_in, input int gap, input bit toggle,
                            input int n_out, input int exp_cycles, input bit full);
    int ip = 0, op = 0, cyc = 0, gapc = 0, fa = -1, fv = -1;
    bit stalled = 1'b0;
    logic [7:0] held = 8'h00;
    while (op < n_out && cyc < 400) begin
      in_valid  = (ip < n_in) && (gapc == 0);
      in_data   = in_valid ? in_vec[ip] : 8'h00;
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (stalled) begin
        check({name, " stall_valid"}, 32'(o_valid), 32'd1);
        check({name, " stall_hold"}, 32'(o_data), 32'(held));
      end
      if (o_valid && fv < 0) fv = cyc;
      if (o_valid && out_ready) begin
        check({name, " beat"}, 32'(o_data), 32'(exp_vec[op]));
        op++;
      end
      stalled = o_valid && !out_ready;
      held    = o_data;
      if (in_valid && i_ready) begin
        if (fa < 0) fa = cyc;
        if (op < n_out) check({name, " accept_pos"}, 32'(in_data), 32'(exp_vec[op]));
        ip++;
        gapc = gap;
      end else if (gapc > 0) begin
        gapc--;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check({name, " beats"}, 32'(op), 32'(n_out));
    check({name, " first_valid"}, 32'(fv), 32'(fa + 1));
    if (exp_cycles > 0) check({name, " cycles"}, 32'(cyc), 32'(exp_cycles));
    if (full) begin
      #1;
      check({name, " drain_valid"}, 32'(o_valid), 32'd0);
      check({name, " inputs_used"}, 32'(ip), 32'(n_in));
    end
  endtask

  initial begin
    rst       = 1'b1;
    use_pass  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("reset a_valid", 32'(a_out_valid), 32'd0);
    check("reset a_data", 32'(a_out), 32'd0);
    check("reset a_ready", 32'(a_in_ready), 32'd0);
    check("reset p_ready", 32'(p_in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    load_frame(0, 8'd1, 8'd2, 8'd3, 8'd4);
    run_stream("basic", 4, 0, 1'b0, 16, 17, 1'b1);
    run_stream("backpressure", 4, 0, 1'b1, 16, 0, 1'b1);
    run_stream("in_gaps", 4, 3, 1'b0, 16, 0, 1'b1);

    load_frame(1, 8'd5, 8'd6, 8'd7, 8'd8);
    run_stream("two_frames", 8, 0, 1'b0, 32, 33, 1'b1);

    use_pass = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_vec[k]  = 8'(k);
      exp_vec[k] = 8'(k);
    end
    run_stream("passthrough", 16, 0, 1'b0, 16, 17, 1'b1);
    use_pass = 1'b0;

    load_frame(0, 8'd1, 8'd2, 8'd3, 8'd4);
    run_stream("pre_reset", 4, 0, 1'b0, 6, 0, 1'b0);
    rst = 1'b1;
    #1;
    check("midreset valid", 32'(a_out_valid), 32'd0);
    check("midreset data", 32'(a_out), 32'd0);
    check("midreset ready", 32'(a_in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_frame(0, 8'd9, 8'd9, 8'd9, 8'd9);
    run_stream("post_reset", 4, 0, 1'b0, 16, 17, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
